// File: rtl/router_out_port.sv
// Output port of a packet router: round-robin arbitration across N input channels
// with packet locking, a per-beat data transform and a one-deep registered output stage.
module router_out_port #(
  parameter int W  = 16,
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  input  logic [2*N-1:0] in_op,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  output logic           out_last,
  input  logic           out_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] lock_ch_reg, lock_ch_next;
  logic [SW-1:0] rr_ptr_reg, rr_ptr_next;

  logic          out_valid_reg;
  logic [W-1:0]  out_data_reg;
  logic [SW-1:0] out_src_reg;
  logic          out_last_reg;

  logic [W-1:0]  ch_data [N];
  logic [1:0]    ch_op   [N];

  logic          load_allowed;
  logic          load;
  logic [SW-1:0] grant;
  logic          eligible;
  logic [SW-1:0] search_grant;
  logic          search_found;
  logic [SW:0]   idx_wide;
  logic [W-1:0]  raw_data;
  logic [1:0]    sel_op;
  logic [W-1:0]  sel_data;
  logic          sel_last;

  assign load_allowed = !out_valid_reg || out_ready;

  // in_ready depends only on valids, output handshake and registered state.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*W +: W];
      assign ch_op[gi]    = in_op[2*gi +: 2];
      assign in_ready[gi] = rst_n && load_allowed && (grant == SW'(gi));
    end
  endgenerate

  // Descending scan so the last hit is the first valid channel at or above rr_ptr.
  always_comb begin
    search_grant = rr_ptr_reg;
    search_found = 1'b0;
    idx_wide     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_wide = {1'b0, rr_ptr_reg} + (SW+1)'(i);
      if (idx_wide >= (SW+1)'(N)) begin
        idx_wide = idx_wide - (SW+1)'(N);
      end
      if (in_valid[idx_wide]) begin
        search_grant = idx_wide[SW-1:0];
        search_found = 1'b1;
      end
    end
  end

  always_comb begin
    grant    = search_grant;
    eligible = search_found;
    if (state_reg == LOCKED) begin
      grant    = lock_ch_reg;
      eligible = in_valid[lock_ch_reg];
    end
  end

  assign load = load_allowed && eligible;

  always_comb begin
    raw_data = ch_data[grant];
    sel_op   = ch_op[grant];
    sel_last = in_last[grant];
    case (sel_op)
      2'b00:   sel_data = raw_data;
      2'b01:   sel_data = ~raw_data;
      2'b10:   sel_data = {raw_data[W-2:0], raw_data[W-1]};
      default: sel_data = {raw_data[0], raw_data[W-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      lock_ch_reg <= '0;
      rr_ptr_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      lock_ch_reg <= lock_ch_next;
      rr_ptr_reg  <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    lock_ch_next = lock_ch_reg;
    rr_ptr_next  = rr_ptr_reg;
    if (load) begin
      if (sel_last) begin
        state_next  = IDLE;
        rr_ptr_next = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
      end else if (state_reg == IDLE) begin
        state_next   = LOCKED;
        lock_ch_next = grant;
      end
    end
  end

  // A load replaces the held beat in the same cycle it drains, so no bubble appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      out_last_reg  <= 1'b0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= sel_data;
      out_src_reg   <= grant;
      out_last_reg  <= sel_last;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_router_out_port.sv
// Directed bench for router_out_port: expected beats go into a scoreboard queue when
// driven and are compared as they leave the output port; a second N=3 instance covers wrap.
module tb_router_out_port;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int SW = 2;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] src;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [2*N-1:0] in_op;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_last;
  logic           out_ready;

  logic [2:0]  in_valid3;
  logic [23:0] in_data3;
  logic [5:0]  in_op3;
  logic [2:0]  in_last3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_src3;
  logic        out_last3;
  logic        out_ready3;

  router_out_port #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_op(in_op), .in_last(in_last),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_last(out_last),
    .out_ready(out_ready)
  );

  router_out_port #(.W(8), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_data(in_data3), .in_op(in_op3), .in_last(in_last3),
    .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_src(out_src3), .out_last(out_last3),
    .out_ready(out_ready3)
  );

  int    vectors     = 0;
  int    miscompares = 0;
  beat_t sb[$];
  beat_t exp_beat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic v, input logic [W-1:0] d,
                        input logic [1:0] op, input logic l);
    in_valid[k]      = v;
    in_data[k*W +: W] = d;
    in_op[2*k +: 2]  = op;
    in_last[k]       = l;
  endtask

  task automatic push(input logic [W-1:0] d, input logic [SW-1:0] s, input logic l);
    beat_t b;
    b.data = d;
    b.src  = s;
    b.last = l;
    sb.push_back(b);
  endtask

  // Scoreboard: every beat accepted downstream must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        exp_beat = sb.pop_front();
        check("sb_data", 64'(out_data), 64'(exp_beat.data));
        check("sb_src",  64'(out_src),  64'(exp_beat.src));
        check("sb_last", 64'(out_last), 64'(exp_beat.last));
        $display("beat: data=0x%04h src=%0d last=%0d", out_data, out_src, out_last);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = '1;
    in_data    = '0;
    in_op      = '0;
    in_last    = '0;
    out_ready  = 1'b0;
    in_valid3  = '1;
    in_data3   = '0;
    in_op3     = '0;
    in_last3   = '0;
    out_ready3 = 1'b1;

    // Reset state, with every channel requesting.
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_src",   64'(out_src),   64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_in_ready3", 64'(in_ready3), 64'd0);
    in_valid  = '0;
    in_valid3 = '0;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // ch2 alone, rotate-left of 0x8001; first edge after release loads.
    set_ch(2, 1'b1, 16'h8001, 2'b10, 1'b1);
    #1;
    check("t1_in_ready", 64'(in_ready), 64'b0100);
    push(16'h0003, 2'd2, 1'b1);
    step();
    check("t1_out_valid", 64'(out_valid), 64'd1);
    set_ch(2, 1'b0, 16'h0, 2'b00, 1'b0);
    // rr_ptr now 3: ch3 wins over ch0.
    set_ch(0, 1'b1, 16'hA000, 2'b00, 1'b1);
    set_ch(3, 1'b1, 16'hA003, 2'b00, 1'b1);
    #1;
    check("t1_rr3_in_ready", 64'(in_ready), 64'b1000);
    push(16'hA003, 2'd3, 1'b1);
    step();
    in_valid = '0;

    // All four valid with single-beat packets: 0,1,2,3,0 with no bubbles.
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < N; k++) begin
        set_ch(k, 1'b1, 16'((c + 1) * 16'h100 + k), 2'b00, 1'b1);
      end
      #1;
      check("t2_in_ready", 64'(in_ready), 64'(4'b0001 << (c % 4)));
      push(16'((c + 1) * 16'h100 + (c % 4)), 2'(c % 4), 1'b1);
      step();
      check("t2_no_bubble", 64'(out_valid), 64'd1);
    end
    in_valid = '0;

    // ch1 3-beat packet while ch0 and ch3 wait; one-cycle gap inside the packet.
    set_ch(0, 1'b1, 16'hB000, 2'b00, 1'b1);
    set_ch(3, 1'b1, 16'hB003, 2'b00, 1'b1);
    set_ch(1, 1'b1, 16'h0F0F, 2'b01, 1'b0);
    #1;
    check("t3_beat1_ready", 64'(in_ready), 64'b0010);
    push(16'hF0F0, 2'd1, 1'b0);
    step();
    in_valid[1] = 1'b0;
    #1;
    check("t3_gap_ready", 64'(in_ready), 64'b0010);
    step();
    check("t3_gap_drained", 64'(out_valid), 64'd0);
    set_ch(1, 1'b1, 16'h1234, 2'b00, 1'b0);
    #1;
    check("t3_beat2_ready", 64'(in_ready), 64'b0010);
    push(16'h1234, 2'd1, 1'b0);
    step();
    set_ch(1, 1'b1, 16'h4001, 2'b11, 1'b1);
    #1;
    check("t3_beat3_ready", 64'(in_ready), 64'b0010);
    push(16'hA000, 2'd1, 1'b1);
    step();
    in_valid[1] = 1'b0;
    #1;
    check("t3_after_ready", 64'(in_ready), 64'b1000);
    push(16'hB003, 2'd3, 1'b1);
    step();
    in_valid[3] = 1'b0;
    #1;
    check("t3_ch0_ready", 64'(in_ready), 64'b0001);
    push(16'hB000, 2'd0, 1'b1);
    step();
    in_valid = '0;

    // Output stall for three cycles with inverted 0x00FF held.
    set_ch(1, 1'b1, 16'h00FF, 2'b01, 1'b1);
    #1;
    check("t4_load_ready", 64'(in_ready), 64'b0010);
    push(16'hFF00, 2'd1, 1'b1);
    step();
    in_valid[1] = 1'b0;
    out_ready   = 1'b0;
    set_ch(2, 1'b1, 16'h5678, 2'b00, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t4_stall_ready", 64'(in_ready),  64'd0);
      check("t4_stall_data",  64'(out_data),  64'hFF00);
      check("t4_stall_src",   64'(out_src),   64'd1);
      check("t4_stall_valid", 64'(out_valid), 64'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("t4_release_ready", 64'(in_ready), 64'b0100);
    push(16'h5678, 2'd2, 1'b1);
    step();
    check("t4_replaced", 64'(out_data), 64'h5678);
    in_valid = '0;

    // Reset in the middle of a 4-beat ch3 packet.
    set_ch(3, 1'b1, 16'h3001, 2'b00, 1'b0);
    #1;
    check("t5_beat1_ready", 64'(in_ready), 64'b1000);
    push(16'h3001, 2'd3, 1'b0);
    step();
    set_ch(3, 1'b1, 16'h3002, 2'b00, 1'b0);
    #1;
    check("t5_beat2_ready", 64'(in_ready), 64'b1000);
    push(16'h3002, 2'd3, 1'b0);
    step();
    rst_n = 1'b0;
    set_ch(3, 1'b1, 16'h3003, 2'b00, 1'b0);
    set_ch(0, 1'b1, 16'h0C00, 2'b00, 1'b1);
    check("t5_pending", 64'(sb.size()), 64'd1);
    sb.delete();
    #1;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_data",  64'(out_data),  64'd0);
    check("t5_rst_src",   64'(out_src),   64'd0);
    check("t5_rst_ready", 64'(in_ready),  64'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("t5_post_ready", 64'(in_ready), 64'b0001);
    push(16'h0C00, 2'd0, 1'b1);
    step();
    in_valid[0] = 1'b0;
    set_ch(3, 1'b1, 16'h3004, 2'b00, 1'b1);
    #1;
    check("t5_ch3_ready", 64'(in_ready), 64'b1000);
    push(16'h3004, 2'd3, 1'b1);
    step();
    in_valid = '0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check("drain_empty", 64'(sb.size()), 64'd0);

    // N=3, W=8: round robin wraps 2 -> 0; op 11 on 0x01 gives 0x80.
    in_valid3 = 3'b111;
    in_last3  = 3'b111;
    in_data3  = {8'h12, 8'h11, 8'h01};
    in_op3    = {2'b00, 2'b00, 2'b11};
    for (int c = 0; c < 4; c++) begin
      #1;
      check("n3_in_ready", 64'(in_ready3), 64'(3'b001 << (c % 3)));
      step();
      check("n3_out_src",  64'(out_src3),  64'(c % 3));
      check("n3_out_data", 64'(out_data3), (c % 3 == 0) ? 64'h80 : 64'(8'h10 + (c % 3)));
      check("n3_out_last", 64'(out_last3), 64'd1);
      $display("n3 beat: data=0x%02h src=%0d", out_data3, out_src3);
    end
    in_valid3 = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_out_port.md
ROUTER_OUT_PORT -- requirements
Module: router_out_port

Interface
REQ-001 Parameter W, default 16, payload width in bits (W >= 2).
REQ-002 Parameter N, default 4, number of input channels (2..16).
REQ-003 Parameter SW, default $clog2(N), source-index width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  N  per-channel beat valid.
REQ-007 in_data  input  N*W  per-channel payload; channel k occupies bits [k*W +: W].
REQ-008 in_op  input  2*N  per-channel transform code; channel k occupies bits [2k +: 2].
REQ-009 in_last  input  N  per-channel end-of-packet marker.
REQ-010 in_ready  output  N  per-channel accept; a beat transfers when in_valid[k] & in_ready[k].
REQ-011 out_valid  output  1  output beat valid.
REQ-012 out_data  output  W  transformed payload.
REQ-013 out_src  output  SW  index of the channel that supplied out_data.
REQ-014 out_last  output  1  end-of-packet marker of the output beat.
REQ-015 out_ready  input  1  downstream accept; a beat leaves when out_valid & out_ready.

Function
REQ-016 Output register loads when load = (!out_valid | out_ready) and at least one eligible channel has in_valid set; the register holds otherwise.
REQ-017 Latency is exactly one cycle from input transfer to out_valid, and a full rate of one beat per cycle is sustained while out_ready = 1.
REQ-018 At most one in_ready bit is high per cycle: in_ready[g] = load_allowed & (g == grant), where load_allowed = (!out_valid | out_ready).
REQ-019 in_ready is a combinational function of in_valid, out_valid, out_ready and registered state only; it has no path from in_data, in_op or in_last.
REQ-020 Transform: op 00 passes data; op 01 inverts every bit; op 10 rotates left by 1 (bit 0 receives bit W-1); op 11 rotates right by 1 (bit W-1 receives bit 0).
REQ-021 out_src = grant index; out_last = in_last[grant], both captured with out_data.
REQ-022 The FSM has two states, IDLE and LOCKED, and holds lock_ch (SW bits) and rr_ptr (SW bits).
REQ-023 In IDLE, grant is the first valid channel searching upward from rr_ptr, wrapping from N-1 to 0.
REQ-024 In IDLE, a transfer with in_last = 0 moves the FSM to LOCKED with lock_ch = grant.
REQ-025 In IDLE, a transfer with in_last = 1 leaves the FSM in IDLE.
REQ-026 In LOCKED, only lock_ch is eligible, and other channels see in_ready = 0 regardless of in_valid.
REQ-027 In LOCKED, a transfer with in_last = 1 returns the FSM to IDLE.
REQ-028 On every transfer with in_last = 1, rr_ptr becomes (grant+1) mod N; N that is not a power of 2 wraps to 0 after N-1.
REQ-029 rr_ptr is unchanged by transfers with in_last = 0.
REQ-030 If no channel is valid, no load occurs and out_valid clears once the held beat is accepted.
REQ-031 LOCKED with in_valid[lock_ch] = 0: no load, FSM stays LOCKED, and no other channel is served.
REQ-032 When the output is stalled (out_valid=1, out_ready=0), all in_ready = 0, and out_data/out_src/out_last stay stable.
REQ-033 Simultaneous output drain and input load in the same cycle replaces the beat without a bubble.

Reset
REQ-034 While rst_n = 0: out_valid=0, out_data=0, out_src=0, out_last=0, in_ready=0, FSM=IDLE, rr_ptr=0, lock_ch=0.
REQ-035 Reset asserted mid-packet aborts the lock, and the first grant after release follows IDLE rules from rr_ptr=0.
REQ-036 The first load can occur on the first rising clk edge after rst_n deasserts.

Verification
REQ-037 W=16, N=4: ch2 valid alone, data 0x8001, op 10, last 1 -> next cycle out_data=0x0003, out_src=2, out_last=1; rr_ptr=3.
REQ-038 All four channels valid with single-beat packets, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
REQ-039 ch1 sends a 3-beat packet while ch0 and ch3 are valid throughout -> out_src=1,1,1 then 3 (rr_ptr=2, search 2,3); in_ready[0] and in_ready[3] stay 0 during the lock.
REQ-040 Hold out_ready=0 for 3 cycles with beat 0x00FF op 01 loaded -> out_data stays 0xFF00 and all in_ready=0; on release the beat transfers and the next beat loads in the same cycle.
REQ-041 Assert rst_n=0 after beat 2 of a 4-beat ch3 packet -> outputs clear immediately; after release with ch0 and ch3 valid, ch0 is granted first.
REQ-042 Parameter sweep N=3, W=8: wrap from ch2 to ch0; op 11 on 0x01 -> 0x80.
